seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle signed ALU that succeeds the combinational N-bit ALU.
- Adds a clock, a valid/ready handshake on both the request and response sides, and iterative shift-add multiply and restoring divide.
- Adds a remainder (MOD) operation.
- Sits between the CPU decode/issue stage and writeback; one operation in flight at a time.

Parameters:
- N, default 8: operand width in bits, signed two's complement, N >= 4.
- OP_W, default 3: opcode width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in1  in  N  signed operand A.
- in2  in  N  signed operand B.
- op  in  OP_W  operation select.
- invalid_data  in  1  request carries poisoned operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  2N  signed result.
- zero  out  1  out == 0.
- error  out  1  illegal op, divide by zero, or invalid_data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (on a clk edge with rst=1): state=IDLE; out_valid=0; out=0; zero=0; error=0; busy=0; in_ready=1. rst has priority over all other events.
- Accept: a request is taken on a rising edge where in_valid && in_ready. in_ready = (state==IDLE). Operands and op are registered at accept; later input changes are ignored.
- Opcodes:
  - 0 ADD
  - 1 SUB (in1-in2)
  - 2 MUL
  - 3 DIV
  - 4 MOD
  - 5-7 illegal
- Width rules:
  - ADD/SUB: operands sign-extended to 2N before the operation; never overflows.
  - MUL: full 2N-bit signed product.
  - DIV: quotient truncates toward zero, sign-extended to 2N. (-2^(N-1))/(-1) = +2^(N-1), representable.
  - MOD: remainder carries the dividend's sign; |rem| < |in2|.
- Latency, measured in edges from the accept edge to the edge that sets out_valid=1:
  - ADD, SUB, illegal op, invalid_data, and DIV/MOD with in2==0: 1.
  - MUL, DIV, MOD: N+1. This is N iteration cycles on magnitudes plus 1 sign-fixup cycle.
- Error cases: illegal op, in2==0 for DIV/MOD, or invalid_data=1 at accept give out=0, error=1, zero=0. invalid_data takes precedence over op decode.
- zero = (out==0) && !error, registered together with out.
- FSM states:
  - IDLE: on accept, go to DONE (1-cycle ops and error cases), MUL, or DIV (DIV and MOD).
  - MUL: shift-add, count N-1 down to 0, then FIX.
  - DIV: restore step, count N-1 down to 0, then FIX.
  - FIX: apply sign correction, load out/zero/error, go to DONE.
  - DONE: out_valid=1; go to IDLE on out_ready.
- DONE entry sets out_valid=1 on the same edge.
- Backpressure: out, zero and error are held stable while out_valid && !out_ready.
- Completion: out_valid drops on the edge where out_valid && out_ready. No new request is accepted in DONE, so there is one bubble between back-to-back operations.
- Reset mid-operation: the in-flight operation is discarded and no out_valid pulse occurs.
- in_valid while busy: no effect; the request must be held by the producer.

Decomposition:
- Package alu_pkg holds:
  - op enum: OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD.
  - state enum: IDLE, MUL, DIV, FIX, DONE.
  - localparam OP_W.
  - function is_legal_op.
- Sub-module alu_iter_unit: iterative unsigned N×N multiply / N÷N restoring divide on magnitudes.
  - Inputs: start, mode, a_mag, b_mag.
  - Outputs: done, prod[2N], quot[N], rem[N].
  - seq_alu owns the handshake, sign handling, 1-cycle ops and the FSM.

Test Plan:
- N=8, ADD 15+15; then SUB -128-127 → out=30 (latency 1, zero=0), then out=-255 (16'hFF01); in_ready=0 only during each op.
- MUL -128*-128 → out=16384 exactly 9 edges after accept. Then MUL 10*-10 → out=-100. Then MUL 0*77 → out=0, zero=1.
- DIV 13/3 → out=4; MOD 13%3 → 1; DIV -25/4 → -6; MOD -25%4 → -1; DIV -128/-1 → 128. Each has 9-edge latency.
- DIV 10/0 → out=0, error=1, latency 1. op=7 → error=1. invalid_data=1 with ADD 10+-10 → error=1, zero=0.
- MUL 25*-5 with out_ready=0 for 5 cycles after out_valid:
  - out=-125 held stable.
  - in_ready=0; a new in_valid is ignored.
  - out_ready=1 → out_valid=0 next edge; in_ready=1.
- Assert rst 4 edges into MUL 100*100 → next edge out_valid=0, busy=0, in_ready=1. No result is ever emitted; a following ADD 1+1 returns 2 normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/state encodings for the sequential signed ALU.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV,
    OP_MOD
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_e;

  function automatic logic is_legal_op(input int unsigned op);
    return op <= 32'(OP_MOD);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative unsigned N x N shift-add multiply / N / N restoring divide on magnitudes.
// The first step runs on the start edge, so N steps complete N-1 edges later.
module alu_iter_unit #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic           i_mode,
  input  logic [N-1:0]   i_a_mag,
  input  logic [N-1:0]   i_b_mag,
  output logic           o_done,
  output logic [2*N-1:0] o_prod,
  output logic [N-1:0]   o_quot,
  output logic [N-1:0]   o_rem
);
  localparam int unsigned CntW = $clog2(N);

  logic            r_busy;
  logic            r_mode;
  logic [CntW-1:0] r_cnt;
  logic [2*N-1:0]  r_mul_a;
  logic [N-1:0]    r_mul_b;
  logic [2*N-1:0]  r_acc;
  logic [N-1:0]    r_div_q;
  logic [N-1:0]    r_div_r;
  logic [N-1:0]    r_div_b;

  logic            w_mode;
  logic [2*N-1:0]  w_mul_a;
  logic [N-1:0]    w_mul_b;
  logic [2*N-1:0]  w_acc;
  logic [N-1:0]    w_div_q;
  logic [N-1:0]    w_div_r;
  logic [N-1:0]    w_div_b;
  logic [N:0]      w_shift;
  logic [N:0]      w_trial;

  // On start the step operates on the fresh operands instead of the registers.
  always_comb begin
    w_mode  = i_start ? i_mode : r_mode;
    w_mul_a = i_start ? {{N{1'b0}}, i_a_mag} : r_mul_a;
    w_mul_b = i_start ? i_b_mag : r_mul_b;
    w_acc   = i_start ? '0 : r_acc;
    w_div_q = i_start ? i_a_mag : r_div_q;
    w_div_r = i_start ? '0 : r_div_r;
    w_div_b = i_start ? i_b_mag : r_div_b;
    w_shift = {w_div_r, w_div_q[N-1]};
    w_trial = w_shift - {1'b0, w_div_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_acc   <= '0;
      r_div_q <= '0;
      r_div_r <= '0;
      r_div_b <= '0;
    end else begin
      if (i_start) begin
        r_busy <= 1'b1;
        r_mode <= i_mode;
        r_cnt  <= CntW'(N - 2);
      end else if (r_busy && (r_cnt == '0)) begin
        r_busy <= 1'b0;
      end else if (r_busy) begin
        r_cnt <= r_cnt - CntW'(1);
      end
      if (i_start || r_busy) begin
        if (w_mode) begin
          r_div_b <= w_div_b;
          r_div_q <= {w_div_q[N-2:0], ~w_trial[N]};
          r_div_r <= w_trial[N] ? w_shift[N-1:0] : w_trial[N-1:0];
        end else begin
          r_acc   <= w_acc + (w_mul_b[0] ? w_mul_a : '0);
          r_mul_a <= w_mul_a << 1;
          r_mul_b <= w_mul_b >> 1;
        end
      end
    end
  end

  assign o_done = r_busy && (r_cnt == '0);
  assign o_prod = r_acc;
  assign o_quot = r_div_q;
  assign o_rem  = r_div_r;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle signed ALU with valid/ready on both sides; one operation in flight.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned OP_W = alu_pkg::OP_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in1,
  input  logic [N-1:0]    in2,
  input  logic [OP_W-1:0] op,
  input  logic            invalid_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  out,
  output logic            zero,
  output logic            error,
  output logic            busy
);
  localparam logic [OP_W-1:0] CodeSub = OP_W'(OP_SUB);
  localparam logic [OP_W-1:0] CodeAdd = OP_W'(OP_ADD);
  localparam logic [OP_W-1:0] CodeMul = OP_W'(OP_MUL);
  localparam logic [OP_W-1:0] CodeDiv = OP_W'(OP_DIV);
  localparam logic [OP_W-1:0] CodeMod = OP_W'(OP_MOD);

  state_e          r_state, w_state_next;
  logic [OP_W-1:0] r_op;
  logic            r_a_neg, r_b_neg;
  logic [2*N-1:0]  r_out;
  logic            r_zero, r_error;

  logic            w_accept, w_in_div, w_in_short, w_in_err, w_load, w_res_err;
  logic [N-1:0]    w_a_mag, w_b_mag;
  logic [2*N-1:0]  w_a_ext, w_b_ext, w_imm, w_fix, w_res;
  logic            w_iter_done;
  logic [2*N-1:0]  w_iter_prod;
  logic [N-1:0]    w_iter_quot, w_iter_rem;

  always_comb begin
    w_accept   = in_valid && (r_state == IDLE);
    w_in_div   = (op == CodeDiv) || (op == CodeMod);
    w_in_short = (op == CodeAdd) || (op == CodeSub);
    // Poisoned data wins over any opcode decode.
    w_in_err   = invalid_data || !is_legal_op(32'(op)) || (w_in_div && (in2 == '0));
    w_a_mag    = in1[N-1] ? -in1 : in1;
    w_b_mag    = in2[N-1] ? -in2 : in2;
    w_a_ext    = {{N{in1[N-1]}}, in1};
    w_b_ext    = {{N{in2[N-1]}}, in2};
    w_imm      = '0;
    if (!w_in_err) w_imm = (op == CodeSub) ? w_a_ext - w_b_ext : w_a_ext + w_b_ext;
  end

  always_comb begin
    if (r_op == CodeMul) begin
      w_fix = (r_a_neg ^ r_b_neg) ? -w_iter_prod : w_iter_prod;
    end else if (r_op == CodeDiv) begin
      w_fix = {{N{1'b0}}, w_iter_quot};
      if (r_a_neg ^ r_b_neg) w_fix = -w_fix;
    end else begin
      // Remainder follows the dividend's sign.
      w_fix = {{N{1'b0}}, w_iter_rem};
      if (r_a_neg) w_fix = -w_fix;
    end
    w_load    = (w_accept && (w_in_err || w_in_short)) || (r_state == FIX);
    w_res     = (r_state == FIX) ? w_fix : w_imm;
    w_res_err = (r_state != FIX) && w_in_err;
  end

  alu_iter_unit #(
    .N(N)
  ) u_iter (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_accept && !w_in_err && !w_in_short),
    .i_mode  (w_in_div),
    .i_a_mag (w_a_mag),
    .i_b_mag (w_b_mag),
    .o_done  (w_iter_done),
    .o_prod  (w_iter_prod),
    .o_quot  (w_iter_quot),
    .o_rem   (w_iter_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_in_err || w_in_short) w_state_next = DONE;
          else if (w_in_div)          w_state_next = DIV;
          else                        w_state_next = MUL;
        end
      end
      MUL, DIV: if (w_iter_done) w_state_next = FIX;
      FIX:      w_state_next = DONE;
      DONE:     if (out_ready) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= '0;
      r_a_neg <= 1'b0;
      r_b_neg <= 1'b0;
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= op;
        r_a_neg <= in1[N-1];
        r_b_neg <= in2[N-1];
      end
      if (w_load) begin
        r_out   <= w_res;
        r_error <= w_res_err;
        r_zero  <= (w_res == '0) && !w_res_err;
      end
    end
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    busy      = (r_state != IDLE);
    out_valid = (r_state == DONE);
    out       = r_out;
    zero      = r_zero;
    error     = r_error;
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (N=8): arithmetic, errors, latency, backpressure, mid-op reset.
module tb_seq_alu;
  localparam int unsigned N = 8;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, invalid_data;
  logic          out_valid, out_ready, zero, error, busy;
  logic [N-1:0]  in1, in2;
  logic [2:0]    op;
  logic [2*N-1:0] out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_alu #(
    .N    (N),
    .OP_W (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in1          (in1),
    .in2          (in2),
    .op           (op),
    .invalid_data (invalid_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out          (out),
    .zero         (zero),
    .error        (error),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Latency counts edges from the accept edge (inclusive) to the edge raising out_valid.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] opc, input logic inv, input logic [15:0] exp_out,
                        input logic exp_err, input logic exp_zero, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, ".ready_before"}, 32'(in_ready), 32'(1));
    in1 = a; in2 = b; op = opc; invalid_data = inv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs after accept: the in-flight operation must not notice.
    in_valid = 1'b0; in1 = ~a; in2 = ~b; op = 3'd7; invalid_data = 1'b1;
    check({tag, ".ready_during"}, 32'(in_ready), 32'(0));
    wait_result(lat);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".out"}, 32'(out), 32'(exp_out));
    check({tag, ".error"}, 32'(error), 32'(exp_err));
    check({tag, ".zero"}, 32'(zero), 32'(exp_zero));
    @(posedge clk);
    #1;
    check({tag, ".valid_drop"}, 32'(out_valid), 32'(0));
    check({tag, ".ready_after"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    int lat;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; invalid_data = 1'b0;
    in1 = '0; in2 = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(out_valid), 32'(0));
    check("rst.in_ready", 32'(in_ready), 32'(1));
    check("rst.busy", 32'(busy), 32'(0));
    check("rst.out", 32'(out), 32'(0));
    check("rst.error", 32'(error), 32'(0));
    check("rst.zero", 32'(zero), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    run_op("add", 8'd15, 8'd15, 3'd0, 1'b0, 16'd30, 1'b0, 1'b0, 1);
    run_op("sub", 8'h80, 8'd127, 3'd1, 1'b0, 16'hFF01, 1'b0, 1'b0, 1);
    run_op("mul_nn", 8'h80, 8'h80, 3'd2, 1'b0, 16'h4000, 1'b0, 1'b0, 9);
    run_op("mul_pn", 8'd10, 8'hF6, 3'd2, 1'b0, 16'hFF9C, 1'b0, 1'b0, 9);
    run_op("mul_0", 8'd0, 8'd77, 3'd2, 1'b0, 16'h0000, 1'b0, 1'b1, 9);
    run_op("div_13_3", 8'd13, 8'd3, 3'd3, 1'b0, 16'd4, 1'b0, 1'b0, 9);
    run_op("mod_13_3", 8'd13, 8'd3, 3'd4, 1'b0, 16'd1, 1'b0, 1'b0, 9);
    run_op("div_m25_4", 8'hE7, 8'd4, 3'd3, 1'b0, 16'hFFFA, 1'b0, 1'b0, 9);
    run_op("mod_m25_4", 8'hE7, 8'd4, 3'd4, 1'b0, 16'hFFFF, 1'b0, 1'b0, 9);
    run_op("div_min_m1", 8'h80, 8'hFF, 3'd3, 1'b0, 16'd128, 1'b0, 1'b0, 9);
    run_op("div_by_0", 8'd10, 8'd0, 3'd3, 1'b0, 16'd0, 1'b1, 1'b0, 1);
    run_op("illegal_op", 8'd3, 8'd4, 3'd7, 1'b0, 16'd0, 1'b1, 1'b0, 1);
    run_op("poisoned", 8'd10, 8'hF6, 3'd0, 1'b1, 16'd0, 1'b1, 1'b0, 1);

    // Backpressure: result held while consumer stalls, new requests ignored.
    @(negedge clk);
    in1 = 8'd25; in2 = 8'hFB; op = 3'd2; invalid_data = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat);
    check("bp.lat", 32'(lat), 32'(9));
    check("bp.out", 32'(out), 32'(16'hFF83));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in1 = 8'd1; in2 = 8'd1; op = 3'd0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp.hold_out", 32'(out), 32'(16'hFF83));
      check("bp.hold_valid", 32'(out_valid), 32'(1));
      check("bp.hold_ready", 32'(in_ready), 32'(0));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.valid_drop", 32'(out_valid), 32'(0));
    check("bp.ready_after", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    check("bp.no_stray_accept", 32'(busy), 32'(0));

    // Reset four edges into a multiply: result must be discarded.
    @(negedge clk);
    in1 = 8'd100; in2 = 8'd100; op = 3'd2; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rstmid.busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid.out_valid", 32'(out_valid), 32'(0));
    check("rstmid.busy", 32'(busy), 32'(0));
    check("rstmid.in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("rstmid.no_result", 32'(seen), 32'(0));
    run_op("add_after_rst", 8'd1, 8'd1, 3'd0, 1'b0, 16'd2, 1'b0, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
